// File: rtl/emesh_pkg.sv
// Shared emesh definitions: channel indices, channel count and packet width derivation.
package emesh_pkg;

   localparam int NCH  = 3;
   localparam int CH_C = 0;
   localparam int CH_R = 1;
   localparam int CH_X = 2;

   typedef logic [1:0] ch_idx_t;

   function automatic int pw_of(input int aw);
      return 2 * aw + 40;
   endfunction

   // Index of the set bit of a one-hot channel vector (0 when empty).
   function automatic ch_idx_t onehot_to_idx(input logic [NCH-1:0] oh);
      ch_idx_t idx;
      idx = '0;
      for (int i = 0; i < NCH; i++) begin
         if (oh[i]) idx = ch_idx_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/emesh_rr_arbiter.sv
// N-way request-to-one-hot grant arbiter; round-robin from the last granted index when
// EMESH_RR_MERGE_FAIR_EN is defined, fixed priority (index 0 highest) otherwise.
module emesh_rr_arbiter #(
   parameter int N = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          update,
   input  logic [IW-1:0] ptr_in,
   output logic [N-1:0]  grant
);

   int            idx;
   logic          found;
   logic [IW-1:0] sel;

`ifdef EMESH_RR_MERGE_FAIR_EN
   logic [IW-1:0] last;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         last <= IW'(N - 1);
      end else if (update) begin
         last <= ptr_in;
      end
   end

   // Search starts at the channel after the last one granted and wraps around.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      grant = '0;
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int off = 1; off <= N; off++) begin
         idx = int'(last) + off;
         if (idx >= N) idx = idx - N;
         sel = IW'(idx);
         if (!found && req[sel]) begin
            grant[sel] = 1'b1;
            found      = 1'b1;
         end
      end
   end
`else
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int i = 0; i < N; i++) begin
         sel = IW'(i);
         if (!found && req[sel]) begin
            grant[sel] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   logic unused_fixed;
   assign unused_fixed = ^{clk, reset, update, ptr_in, idx};
`endif

endmodule

// File: rtl/emesh_rr_merge.sv
// Registered three-way merge of cmesh/rmesh/xmesh onto emesh with one output register.
// Arbitration is round-robin with EMESH_RR_MERGE_FAIR_EN defined, fixed priority c>r>x otherwise.
module emesh_rr_merge
   import emesh_pkg::*;
#(
   parameter int AW = 32,
   parameter int PW = pw_of(AW)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmesh_access_in,
   input  logic [PW-1:0] cmesh_packet_in,
   output logic          cmesh_ready_out,
   input  logic          rmesh_access_in,
   input  logic [PW-1:0] rmesh_packet_in,
   output logic          rmesh_ready_out,
   input  logic          xmesh_access_in,
   input  logic [PW-1:0] xmesh_packet_in,
   output logic          xmesh_ready_out,
   output logic          emesh_access_out,
   output logic [PW-1:0] emesh_packet_out,
   input  logic          emesh_ready_in
);

   logic [NCH-1:0] req;
   logic [NCH-1:0] grant;
   logic [NCH-1:0] ready;
   logic           slot_free;
   logic           in_xfer;
   ch_idx_t        grant_idx;
   logic [PW-1:0]  mux_packet;

   assign req       = {xmesh_access_in, rmesh_access_in, cmesh_access_in};
   assign slot_free = ~emesh_access_out | emesh_ready_in;
   assign ready     = grant & {NCH{slot_free & ~reset}};
   assign in_xfer   = |ready;
   assign grant_idx = onehot_to_idx(grant);

   assign cmesh_ready_out = ready[CH_C];
   assign rmesh_ready_out = ready[CH_R];
   assign xmesh_ready_out = ready[CH_X];

   emesh_rr_arbiter #(.N(NCH)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .update (in_xfer),
      .ptr_in (grant_idx),
      .grant  (grant)
   );

   // Grant is one-hot, so an AND-OR mux suffices.
   always_comb begin
      mux_packet = ({PW{grant[CH_C]}} & cmesh_packet_in)
                 | ({PW{grant[CH_R]}} & rmesh_packet_in)
                 | ({PW{grant[CH_X]}} & xmesh_packet_in);
   end

   // A drain and a new accept in the same cycle reload the register for full throughput.
   always_ff @(posedge clk) begin
      // NOTE: the packet register is reset too, so a dropped packet never leaks after reset.
      if (reset) begin
         emesh_access_out <= 1'b0;
         emesh_packet_out <= '0;
      end else if (in_xfer) begin
         emesh_access_out <= 1'b1;
         emesh_packet_out <= mux_packet;
      end else if (emesh_ready_in) begin
         emesh_access_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_emesh_rr_merge.sv
// Self-checking bench for emesh_rr_merge: behavioural arbitration model plus output scoreboard.
module tb_emesh_rr_merge;

   localparam int AW = 32;
   localparam int PW = 2 * AW + 40;

   logic          clk = 1'b0;
   logic          reset;
   logic          emesh_ready_in;
   logic          acc [3];
   logic [PW-1:0] pkt [3];
   logic          rdy [3];
   logic          emesh_access_out;
   logic [PW-1:0] emesh_packet_out;

   always #5 clk = ~clk;

   emesh_rr_merge #(.AW(AW)) dut (
      .clk              (clk),
      .reset            (reset),
      .cmesh_access_in  (acc[0]),
      .cmesh_packet_in  (pkt[0]),
      .cmesh_ready_out  (rdy[0]),
      .rmesh_access_in  (acc[1]),
      .rmesh_packet_in  (pkt[1]),
      .rmesh_ready_out  (rdy[1]),
      .xmesh_access_in  (acc[2]),
      .xmesh_packet_in  (pkt[2]),
      .xmesh_ready_out  (rdy[2]),
      .emesh_access_out (emesh_access_out),
      .emesh_packet_out (emesh_packet_out),
      .emesh_ready_in   (emesh_ready_in)
   );

   int checks   = 0;
   int failures = 0;

   logic [PW-1:0] src_q [3][$];
   logic [PW-1:0] sb_q [$];
   logic [PW-1:0] out_log [$];
   int            acc_log [$];

   int   m_last;
   logic m_valid;
   int   m_g;
   logic m_sf;

   function automatic int model_grant();
`ifdef EMESH_RR_MERGE_FAIR_EN
      for (int off = 1; off <= 3; off++) begin
         if (acc[(m_last + off) % 3]) return (m_last + off) % 3;
      end
`else
      for (int i = 0; i < 3; i++) begin
         if (acc[i]) return i;
      end
`endif
      return -1;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < 3; i++) begin
         acc[i] = (src_q[i].size() > 0);
         pkt[i] = acc[i] ? src_q[i][0] : '0;
      end
   endtask

   // Sample phase: ready outputs, valid and drained packet against the model/scoreboard.
   task automatic cycle_begin();
      logic          exp_r;
      logic [PW-1:0] exp_p;
      drive_inputs();
      @(negedge clk);
      m_g  = model_grant();
      m_sf = !m_valid || emesh_ready_in;
      for (int i = 0; i < 3; i++) begin
         exp_r = (i == m_g) && m_sf && !reset;
         checks++;
         if (rdy[i] !== exp_r) begin
            failures++;
            $display("FAIL ready_out[%0d]: got %b expected %b at %0t", i, rdy[i], exp_r, $time);
         end
      end
      checks++;
      if (emesh_access_out !== m_valid) begin
         failures++;
         $display("FAIL access_out: got %b expected %b at %0t", emesh_access_out, m_valid, $time);
      end
      if (m_valid && emesh_ready_in) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard: output drained with no expected packet at %0t", $time);
         end else begin
            exp_p = sb_q.pop_front();
            if (emesh_packet_out !== exp_p) begin
               failures++;
               $display("FAIL packet_out: got %0h expected %0h at %0t", emesh_packet_out, exp_p, $time);
            end
         end
         out_log.push_back(emesh_packet_out);
      end
   endtask

   // Edge phase: advance the model with the values that were present at the edge.
   task automatic cycle_end();
      @(posedge clk);
      #1;
      if (reset) begin
         m_valid = 1'b0;
         m_last  = 2;
         sb_q.delete();
      end else if (m_g >= 0 && m_sf) begin
         sb_q.push_back(pkt[m_g]);
         acc_log.push_back(m_g);
         void'(src_q[m_g].pop_front());
         m_valid = 1'b1;
         m_last  = m_g;
      end else if (emesh_ready_in) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic tick();
      cycle_begin();
      cycle_end();
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   task automatic drain();
      bit done;
      emesh_ready_in = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 && !m_valid) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL drain_timeout: traffic still pending after 200 cycles");
      end
   endtask

   task automatic test_reset();
      src_q[0].push_back(PW'('hC0));
      src_q[1].push_back(PW'('hA0));
      src_q[2].push_back(PW'('hB0));
      reset = 1'b1;
      emesh_ready_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle_begin();
         checks++;
         if ({rdy[2], rdy[1], rdy[0]} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ready: got %b%b%b expected 000", rdy[2], rdy[1], rdy[0]);
         end
         checks++;
         if (emesh_access_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_access: got %b expected 0", emesh_access_out);
         end
         checks++;
         if (emesh_packet_out !== '0) begin
            failures++;
            $display("FAIL reset_packet: got %0h expected 0", emesh_packet_out);
         end
         cycle_end();
      end
      reset = 1'b0;
      emesh_ready_in = 1'b1;
      cycle_begin();
      checks++;
      if ({rdy[2], rdy[1], rdy[0]} !== 3'b001) begin
         failures++;
         $display("FAIL first_grant: got %b%b%b expected 001", rdy[2], rdy[1], rdy[0]);
      end
      cycle_end();
      drain();
   endtask

   task automatic test_single_stream();
      acc_log.delete();
      emesh_ready_in = 1'b1;
      for (int v = 1; v <= 4; v++) src_q[1].push_back(PW'(v));
      for (int k = 0; k <= 4; k++) begin
         cycle_begin();
         if (k < 4) begin
            checks++;
            if (rdy[1] !== 1'b1) begin
               failures++;
               $display("FAIL stream_ready: cycle %0d got %b expected 1", k, rdy[1]);
            end
         end
         if (k > 0) begin
            checks++;
            if (emesh_access_out !== 1'b1 || emesh_packet_out !== PW'(k)) begin
               failures++;
               $display("FAIL stream_out: cycle %0d got %b/%0h expected 1/%0h",
                        k, emesh_access_out, emesh_packet_out, k);
            end
         end
         cycle_end();
      end
      drain();
      checks++;
      if (acc_log.size() != 4 || acc_log[0] != 1 || acc_log[3] != 1) begin
         failures++;
         $display("FAIL stream_order: got %0d grants expected 4 rmesh grants", acc_log.size());
      end
   endtask

   task automatic test_contention();
      int exp_n [6];
`ifdef EMESH_RR_MERGE_FAIR_EN
      exp_n = '{12, 10, 11, 12, 10, 11};
`else
      exp_n = '{12, 12, 12, 12, 12, 12};
`endif
      apply_reset(1);
      emesh_ready_in = 1'b1;
      out_log.delete();
      for (int i = 0; i < 6; i++) begin
         src_q[0].push_back(PW'('hC00 + i));
         src_q[1].push_back(PW'('hA00 + i));
         src_q[2].push_back(PW'('hB00 + i));
      end
      repeat (7) tick();
      checks++;
      if (out_log.size() != 6) begin
         failures++;
         $display("FAIL contention_count: got %0d outputs expected 6", out_log.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (int'(out_log[i][11:8]) != exp_n[i]) begin
               failures++;
               $display("FAIL contention_order[%0d]: got %0h expected %0h", i, out_log[i][11:8], exp_n[i]);
            end
         end
      end
      drain();
   endtask

   task automatic test_stall();
      apply_reset(1);
      emesh_ready_in = 1'b1;
      src_q[0].push_back(PW'('h55));
      tick();
      emesh_ready_in = 1'b0;
      src_q[0].push_back(PW'('h77));
      for (int k = 0; k < 4; k++) begin
         cycle_begin();
         checks++;
         if (emesh_access_out !== 1'b1 || emesh_packet_out !== PW'('h55) || rdy[0] !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold: cycle %0d got access=%b packet=%0h ready=%b expected 1/55/0",
                     k, emesh_access_out, emesh_packet_out, rdy[0]);
         end
         cycle_end();
      end
      emesh_ready_in = 1'b1;
      cycle_begin();
      checks++;
      if (rdy[0] !== 1'b1 || emesh_packet_out !== PW'('h55)) begin
         failures++;
         $display("FAIL stall_release: got ready=%b packet=%0h expected 1/55", rdy[0], emesh_packet_out);
      end
      cycle_end();
      cycle_begin();
      checks++;
      if (emesh_access_out !== 1'b1 || emesh_packet_out !== PW'('h77)) begin
         failures++;
         $display("FAIL stall_next: got %b/%0h expected 1/77", emesh_access_out, emesh_packet_out);
      end
      cycle_end();
      drain();
   endtask

   task automatic test_intermittent();
      int exp_ch [6];
`ifdef EMESH_RR_MERGE_FAIR_EN
      exp_ch = '{0, 1, 2, 0, 1, 0};
`else
      exp_ch = '{0, 0, 0, 0, 0, 0};
`endif
      apply_reset(1);
      emesh_ready_in = 1'b1;
      acc_log.delete();
      for (int i = 0; i < 6; i++) begin
         src_q[0].push_back(PW'('hC10 + i));
         src_q[1].push_back(PW'('hA10 + i));
      end
      tick();
      tick();
      src_q[2].push_back(PW'('hB10));
      repeat (4) tick();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (i >= acc_log.size() || acc_log[i] != exp_ch[i]) begin
            failures++;
            $display("FAIL intermittent_order[%0d]: got %0d expected %0d",
                     i, (i < acc_log.size()) ? acc_log[i] : -1, exp_ch[i]);
         end
      end
      drain();
   endtask

   task automatic test_mid_reset();
      apply_reset(1);
      emesh_ready_in = 1'b1;
      src_q[0].push_back(PW'('h11));
      tick();
      emesh_ready_in = 1'b0;
      src_q[1].push_back(PW'('h22));
      tick();
      reset = 1'b1;
      cycle_begin();
      checks++;
      if ({rdy[2], rdy[1], rdy[0]} !== 3'b000 || emesh_access_out !== 1'b1) begin
         failures++;
         $display("FAIL midreset_during: got ready=%b%b%b access=%b expected 000/1",
                  rdy[2], rdy[1], rdy[0], emesh_access_out);
      end
      cycle_end();
      reset = 1'b0;
      src_q[0].push_back(PW'('h33));
      cycle_begin();
      checks++;
      if (emesh_access_out !== 1'b0) begin
         failures++;
         $display("FAIL midreset_access: got %b expected 0", emesh_access_out);
      end
      checks++;
      if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin
         failures++;
         $display("FAIL midreset_priority: got c=%b r=%b expected c=1 r=0", rdy[0], rdy[1]);
      end
      cycle_end();
      drain();
   endtask

   initial begin
      reset = 1'b1;
      emesh_ready_in = 1'b0;
      m_last  = 2;
      m_valid = 1'b0;
      m_g     = -1;
      m_sf    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         acc[i] = 1'b0;
         pkt[i] = '0;
      end
      test_reset();
      test_single_stream();
      test_contention();
      test_stall();
      test_intermittent();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
